// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the single IO_memory port between two requesters. Rev 1.0
// Optional macro IO_PROTECT_EN: suppress requester-1 writes at or above PROTECT_BASE and flag err1.
`default_nettype none

module io_bus_arbiter #(
  parameter int          READ_LATENCY = 1,
  parameter logic [11:0] PROTECT_BASE = 12'hFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [11:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [11:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic        err1,
  output logic        IO_write,
  output logic [11:0] IO_address,
  output logic [15:0] IO_data_in,
  input  logic [15:0] IO_data_out,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef IO_PROTECT_EN
  localparam logic c_prot_en = 1'b1;
`else
  localparam logic c_prot_en = 1'b0;
`endif
  localparam logic [1:0] c_rl = 2'(READ_LATENCY);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        viol_q, viol_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err1_q, err1_d;
  logic [15:0] rd0_q, rd0_d;
  logic [15:0] rd1_q, rd1_d;
  logic        busy_q, busy_d;

  logic        w_pick;
  logic        w_we;
  logic [11:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_viol;
  logic        w_capture;

  // On a tie the requester that did not own the previous transaction wins.
  assign w_pick  = (req0 & req1) ? ~last_q : req1;
  assign w_we    = w_pick ? we1    : we0;
  assign w_addr  = w_pick ? addr1  : addr0;
  assign w_wdata = w_pick ? wdata1 : wdata0;
  assign w_viol  = c_prot_en & w_pick & w_we & (w_addr >= PROTECT_BASE);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    viol_d    = viol_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    wr_d      = 1'b0;
    din_d     = '0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err1_d    = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d = S_ISSUE;
          gnt_d   = w_pick;
          last_d  = w_pick;
          we_d    = w_we;
          viol_d  = w_viol;
          addr_d  = w_addr;
          wr_d    = w_we & ~w_viol;
          din_d   = (w_we & ~w_viol) ? w_wdata : '0;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else if (c_rl == 2'd0) begin
          w_capture = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d   = c_rl;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          w_capture = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_capture) begin
      if (gnt_q) rd1_d = IO_data_out;
      else       rd0_d = IO_data_out;
    end
    // Ack and err are registered on the edge that enters DONE.
    if (state_q != S_DONE && state_d == S_DONE) begin
      ack0_d = ~gnt_q;
      ack1_d = gnt_q;
      err1_d = viol_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      viol_q  <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      viol_q  <= viol_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err1_q  <= err1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err1       = err1_q;
  assign rdata0     = rd0_q;
  assign rdata1     = rd1_q;
  assign IO_write   = wr_q;
  assign IO_address = addr_q;
  assign IO_data_in = din_q;
  assign busy       = busy_q;
  assign grant_id   = gnt_q;

endmodule

`default_nettype wire
